// File: rtl/nfc_atomic_ca_sequencer_if.sv
// Command/address request and NAND pin bundle for the atomic CA sequencer.
// The master side issues requests and watches the pins; the slave side is the sequencer.
interface nfc_atomic_ca_sequencer_if #(
    parameter int NumberOfWays = 4
);
    logic [7:0]              iCommand;
    logic [NumberOfWays-1:0] iTargetWay;
    logic [15:0]             iNumOfData;
    logic                    iCASelect;
    logic [39:0]             iCAData;
    logic                    oReady;
    logic                    oLastStep;
    logic [NumberOfWays-1:0] oCE_n;
    logic                    oCLE;
    logic                    oALE;
    logic                    oWE_n;
    logic                    oRE_n;
    logic [7:0]              oDQ;
    logic                    oDQOE;

    modport master (
        output iCommand, iTargetWay, iNumOfData, iCASelect, iCAData,
        input  oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oRE_n, oDQ, oDQOE
    );

    modport slave (
        input  iCommand, iTargetWay, iNumOfData, iCASelect, iCAData,
        output oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oRE_n, oDQ, oDQOE
    );
endinterface

// File: rtl/nfc_atomic_ca_sequencer.sv
// Atomic NAND command/address latch sequencer.
// Accepts one request (1 command byte or 1..5 address bytes) and toggles WE_n
// once per byte with programmable setup, low and high times. All pin outputs
// come straight from flops.
module nfc_atomic_ca_sequencer #(
    parameter int NumberOfWays = 4,
    parameter int SetupCycles  = 1,
    parameter int WELowCycles  = 2,
    parameter int WEHighCycles = 2
) (
    input  logic                         iSystemClock,
    input  logic                         iReset,
    nfc_atomic_ca_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WLOW  = 3'd2,
        WHIGH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Terminal counts: the shared counter runs 0..N-1 in every timed state.
    localparam logic [3:0] SETUP_LAST  = 4'(SetupCycles - 1);
    localparam logic [3:0] WLOW_LAST   = 4'(WELowCycles - 1);
    localparam logic [3:0] WHIGH_LAST  = 4'(WEHighCycles - 1);

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [2:0]              byte_idx_r;
    logic [2:0]              num_bytes_r;
    logic [39:0]             data_r;
    logic                    ready_r;
    logic                    last_r;
    logic [NumberOfWays-1:0] ce_n_r;
    logic                    cle_r;
    logic                    ale_r;
    logic                    we_n_r;
    logic [7:0]              dq_r;
    logic                    dqoe_r;
    logic                    unused_cmd_bits_s;

    // Number of bytes to issue: one for a command, otherwise count+1 capped at five.
    function automatic logic [2:0] byte_count(input logic ca_sel, input logic [15:0] num);
        logic [2:0] n;
        if (ca_sel) begin
            n = 3'd1;
        end else if (num >= 16'd4) begin
            n = 3'd5;
        end else begin
            n = num[2:0] + 3'd1;
        end
        return n;
    endfunction

    // Byte k of the request, most significant byte first.
    function automatic logic [7:0] byte_of(input logic [39:0] data, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = data[39:32];
            3'd1:    b = data[31:24];
            3'd2:    b = data[23:16];
            3'd3:    b = data[15:8];
            3'd4:    b = data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Sequencer FSM with registered pin outputs.
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            byte_idx_r  <= 3'd0;
            num_bytes_r <= 3'd0;
            data_r      <= 40'h00_0000_0000;
            ready_r     <= 1'b1;
            last_r      <= 1'b0;
            ce_n_r      <= {NumberOfWays{1'b1}};
            cle_r       <= 1'b0;
            ale_r       <= 1'b0;
            we_n_r      <= 1'b1;
            dq_r        <= 8'h00;
            dqoe_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.iCommand[3]) begin
                        state_r     <= SETUP;
                        cnt_r       <= 4'd0;
                        byte_idx_r  <= 3'd0;
                        num_bytes_r <= byte_count(bus.iCASelect, bus.iNumOfData);
                        data_r      <= bus.iCAData;
                        ready_r     <= 1'b0;
                        ce_n_r      <= ~bus.iTargetWay;
                        cle_r       <= bus.iCASelect;
                        ale_r       <= ~bus.iCASelect;
                        we_n_r      <= 1'b1;
                        dq_r        <= bus.iCAData[39:32];
                        dqoe_r      <= 1'b1;
                    end else begin
                        ready_r     <= 1'b1;
                        last_r      <= 1'b0;
                        ce_n_r      <= {NumberOfWays{1'b1}};
                        cle_r       <= 1'b0;
                        ale_r       <= 1'b0;
                        we_n_r      <= 1'b1;
                        dq_r        <= 8'h00;
                        dqoe_r      <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        state_r <= WLOW;
                        cnt_r   <= 4'd0;
                        we_n_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                WLOW: begin
                    if (cnt_r == WLOW_LAST) begin
                        state_r <= WHIGH;
                        cnt_r   <= 4'd0;
                        we_n_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                WHIGH: begin
                    if (cnt_r == WHIGH_LAST) begin
                        cnt_r <= 4'd0;
                        if ((byte_idx_r + 3'd1) < num_bytes_r) begin
                            // Next byte appears together with the falling WE_n.
                            state_r    <= WLOW;
                            byte_idx_r <= byte_idx_r + 3'd1;
                            dq_r       <= byte_of(data_r, byte_idx_r + 3'd1);
                            we_n_r     <= 1'b0;
                        end else begin
                            state_r    <= DONE;
                            last_r     <= 1'b1;
                            cle_r      <= 1'b0;
                            ale_r      <= 1'b0;
                            dqoe_r     <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    cnt_r      <= 4'd0;
                    byte_idx_r <= 3'd0;
                    last_r     <= 1'b0;
                    ready_r    <= 1'b1;
                    ce_n_r     <= {NumberOfWays{1'b1}};
                    dq_r       <= 8'h00;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 4'd0;
                    byte_idx_r <= 3'd0;
                    ready_r    <= 1'b1;
                    last_r     <= 1'b0;
                    ce_n_r     <= {NumberOfWays{1'b1}};
                    cle_r      <= 1'b0;
                    ale_r      <= 1'b0;
                    we_n_r     <= 1'b1;
                    dq_r       <= 8'h00;
                    dqoe_r     <= 1'b0;
                end
            endcase
        end
    end

    // Only bit 3 of the command vector addresses this block.
    assign unused_cmd_bits_s = &{1'b0, bus.iCommand[7:4], bus.iCommand[2:0]};

    assign bus.oReady    = ready_r;
    assign bus.oLastStep = last_r;
    assign bus.oCE_n     = ce_n_r;
    assign bus.oCLE      = cle_r;
    assign bus.oALE      = ale_r;
    assign bus.oWE_n     = we_n_r;
    assign bus.oRE_n     = 1'b1;
    assign bus.oDQ       = dq_r;
    assign bus.oDQOE     = dqoe_r;

endmodule
